storage_cache_controller: RTL and testbench

//  Next-generation storage controller for the vector core's memory port. Splits accesses between
//  an on-chip scratch SRAM (read/write, byte enables) and external SPI flash (read-only).

---
 rtl/storage_cache_controller.sv | 180 ++++++++++++++++++
 tb/tb_storage_cache_controller.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/storage_cache_controller.sv
// Memory-port controller: scratch SRAM, flash reads via a direct-mapped word cache, SPI programming passthrough.
// Latency: SRAM, hit and reject respond 1 cycle after accept; a miss responds 1 cycle after the flash ack.
// Backpressure: one request at a time, held until out_valid; flash stall/ack extend a miss without limit.
module storage_cache_controller #(
  parameter int MEM_W         = 32,
  parameter int SCRATCH_BYTES = 4096,
  parameter int NUM_LINES     = 16,
  parameter int FLASH_AW      = 24
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               memory_access,
  input  logic                               memory_is_writing,
  input  logic [31:0]                        addr,
  input  logic [31:0]                        d_in,
  input  logic [MEM_W/8-1:0]                 mem_be,
  output logic [31:0]                        d_out,
  output logic                               out_valid,
  output logic                               out_err,
  input  logic                               cache_flush,
  input  logic                               set_programming_mode,
  output logic                               prog_active,
  output logic                               sram_cen,
  output logic                               sram_wen,
  output logic [$clog2(SCRATCH_BYTES)-3:0]   sram_addr,
  output logic [31:0]                        sram_d,
  output logic [3:0]                         sram_be,
  input  logic [31:0]                        sram_q,
  output logic                               fl_cyc,
  output logic                               fl_stb,
  output logic [FLASH_AW-3:0]                fl_addr,
  input  logic                               fl_stall,
  input  logic                               fl_ack,
  input  logic [31:0]                        fl_data,
  input  logic                               fl_spi_cs_n,
  input  logic                               fl_spi_sck,
  input  logic                               fl_spi_mosi,
  output logic                               fl_spi_miso,
  output logic                               ext_spi_cs_n,
  output logic                               ext_spi_sck,
  output logic                               ext_spi_mosi,
  input  logic                               ext_spi_miso,
  input  logic                               prog_spi_cs_n,
  input  logic                               prog_spi_sck,
  input  logic                               prog_spi_mosi,
  output logic                               prog_spi_miso
);
  localparam int SA_W  = $clog2(SCRATCH_BYTES) - 2;
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int WA_W  = FLASH_AW - 2;
  localparam int TAG_W = WA_W - IDX_W;

  typedef enum logic [2:0] {IDLE, SRAM_RSP, FL_REQ, FL_WAIT, ERR_RSP, PROG} state_t;

  state_t               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q [NUM_LINES];
  logic [TAG_W-1:0]     tag_d [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES];
  logic [31:0]          data_d [NUM_LINES];
  logic                 rsp_vld_q, rsp_vld_d;
  logic [31:0]          rsp_dat_q, rsp_dat_d;
  logic                 rd_q, rd_d;
  logic [WA_W-1:0]      fl_addr_q, fl_addr_d;

  logic             is_scratch, req_hit, fl_done;
  logic [IDX_W-1:0] req_idx, fl_idx;
  logic [TAG_W-1:0] req_tag, fl_tag;

  assign is_scratch = addr < 32'(SCRATCH_BYTES);
  assign req_idx    = addr[2 +: IDX_W];
  assign req_tag    = addr[2+IDX_W +: TAG_W];
  assign req_hit    = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign fl_idx     = fl_addr_q[IDX_W-1:0];
  assign fl_tag     = fl_addr_q[IDX_W +: TAG_W];
  // An ack in the cycle the stall drops completes the fetch without visiting FL_WAIT.
  assign fl_done    = ((state_q == FL_REQ) && !fl_stall && fl_ack) || ((state_q == FL_WAIT) && fl_ack);

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    tag_d     = tag_q;
    data_d    = data_q;
    rsp_vld_d = 1'b0;
    rsp_dat_d = rsp_dat_q;
    rd_d      = rd_q;
    fl_addr_d = fl_addr_q;
    sram_cen  = 1'b1;
    sram_wen  = 1'b1;
    fl_cyc    = 1'b0;
    fl_stb    = 1'b0;
    case (state_q)
      IDLE: begin
        if (set_programming_mode) begin
          state_d = PROG;
        end else if (cache_flush) begin
          valid_d = '0;
        // The requester still holds its request while a hit response is on the port.
        end else if (memory_access && !rsp_vld_q) begin
          if (is_scratch) begin
            sram_cen = 1'b0;
            sram_wen = ~memory_is_writing;
            rd_d     = ~memory_is_writing;
            state_d  = SRAM_RSP;
          end else if (memory_is_writing) begin
            state_d = ERR_RSP;
          end else if (req_hit) begin
            rsp_vld_d = 1'b1;
            rsp_dat_d = data_q[req_idx];
          end else begin
            fl_addr_d = addr[FLASH_AW-1:2];
            state_d   = FL_REQ;
          end
        end
      end
      SRAM_RSP, ERR_RSP: state_d = IDLE;
      FL_REQ: begin
        fl_cyc = 1'b1;
        fl_stb = 1'b1;
        if (!fl_stall) state_d = FL_WAIT;
      end
      FL_WAIT: fl_cyc = 1'b1;
      PROG: begin
        if (!set_programming_mode) begin
          valid_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fl_done) begin
      valid_d[fl_idx] = 1'b1;
      tag_d[fl_idx]   = fl_tag;
      data_d[fl_idx]  = fl_data;
      rsp_vld_d       = 1'b1;
      rsp_dat_d       = fl_data;
      state_d         = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      rsp_vld_q <= 1'b0;
      rsp_dat_q <= '0;
      rd_q      <= 1'b0;
      fl_addr_q <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_dat_q <= rsp_dat_d;
      rd_q      <= rd_d;
      fl_addr_q <= fl_addr_d;
    end
  end

  assign out_valid = rsp_vld_q || (state_q == SRAM_RSP) || (state_q == ERR_RSP);
  assign out_err   = (state_q == ERR_RSP);
  assign d_out     = (state_q == SRAM_RSP) ? (rd_q ? sram_q : 32'h0) :
                     (rsp_vld_q ? rsp_dat_q : 32'h0);
  assign sram_addr = addr[2 +: SA_W];
  assign sram_d    = d_in;
  assign sram_be   = mem_be;
  assign fl_addr   = fl_addr_q;

  assign prog_active   = (state_q == PROG);
  assign ext_spi_cs_n  = prog_active ? prog_spi_cs_n : fl_spi_cs_n;
  assign ext_spi_sck   = prog_active ? prog_spi_sck  : fl_spi_sck;
  assign ext_spi_mosi  = prog_active ? prog_spi_mosi : fl_spi_mosi;
  assign prog_spi_miso = prog_active ? ext_spi_miso  : 1'b1;
  assign fl_spi_miso   = prog_active ? 1'b1 : ext_spi_miso;
endmodule

// File: tb/tb_storage_cache_controller.sv
// Bench for storage_cache_controller: SRAM and flash-engine models, directed steps then random traffic
// checked against a byte-level scratch model and a per-index line-owner cache model.
module tb_storage_cache_controller;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memory_access = 1'b0, memory_is_writing = 1'b0;
  logic [31:0] addr = '0, d_in = '0;
  logic [3:0]  mem_be = '0;
  logic [31:0] d_out;
  logic        out_valid, out_err, prog_active;
  logic        cache_flush = 1'b0, set_programming_mode = 1'b0;
  logic        sram_cen, sram_wen;
  logic [9:0]  sram_addr;
  logic [31:0] sram_d, sram_q;
  logic [3:0]  sram_be;
  logic        fl_cyc, fl_stb;
  logic [21:0] fl_addr;
  logic        fl_stall = 1'b0, fl_ack = 1'b0;
  logic [31:0] fl_data = '0;
  logic        fl_spi_cs_n = 1'b0, fl_spi_sck = 1'b1, fl_spi_mosi = 1'b0, fl_spi_miso;
  logic        ext_spi_cs_n, ext_spi_sck, ext_spi_mosi, ext_spi_miso = 1'b1;
  logic        prog_spi_cs_n = 1'b1, prog_spi_sck = 1'b0, prog_spi_mosi = 1'b0, prog_spi_miso;

  int checks = 0;
  int errors = 0;

  storage_cache_controller dut (
    .clk(clk), .rst(rst), .memory_access(memory_access), .memory_is_writing(memory_is_writing),
    .addr(addr), .d_in(d_in), .mem_be(mem_be), .d_out(d_out), .out_valid(out_valid), .out_err(out_err),
    .cache_flush(cache_flush), .set_programming_mode(set_programming_mode), .prog_active(prog_active),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_d(sram_d), .sram_be(sram_be),
    .sram_q(sram_q), .fl_cyc(fl_cyc), .fl_stb(fl_stb), .fl_addr(fl_addr), .fl_stall(fl_stall),
    .fl_ack(fl_ack), .fl_data(fl_data), .fl_spi_cs_n(fl_spi_cs_n), .fl_spi_sck(fl_spi_sck),
    .fl_spi_mosi(fl_spi_mosi), .fl_spi_miso(fl_spi_miso), .ext_spi_cs_n(ext_spi_cs_n),
    .ext_spi_sck(ext_spi_sck), .ext_spi_mosi(ext_spi_mosi), .ext_spi_miso(ext_spi_miso),
    .prog_spi_cs_n(prog_spi_cs_n), .prog_spi_sck(prog_spi_sck), .prog_spi_mosi(prog_spi_mosi),
    .prog_spi_miso(prog_spi_miso)
  );

  always #5 clk = ~clk;

  // 1-cycle synchronous SRAM, contents start at zero
  bit [31:0] sram_mem [1024];
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_wen) begin
        for (int k = 0; k < 4; k++)
          if (sram_be[k]) sram_mem[sram_addr][8*k +: 8] <= sram_d[8*k +: 8];
      end else begin
        sram_q <= sram_mem[sram_addr];
      end
    end
  end

  // Flash contents; gen changes when the part is reprogrammed
  logic [9:0]  gen = '0;
  logic [31:0] fixed_2000 = 32'h12345678;
  function automatic logic [31:0] flash_word(input logic [21:0] wa);
    if (wa == 22'h800) return fixed_2000;
    return {gen, wa} ^ 32'h9E3779B9;
  endfunction

  // Flash engine: stalls stall_cfg cycles, then acks ack_cfg cycles after the stb is taken
  int stall_cfg = 0, ack_cfg = 0, stb_cnt = 0;
  initial begin
    int ph, scnt, acnt;
    logic [21:0] cur;
    ph = 0; scnt = 0; acnt = 0; cur = '0;
    forever begin
      @(negedge clk);
      fl_ack = 1'b0;
      if (!rst) begin
        ph = 0;
        fl_stall = 1'b0;
      end else begin
        if (ph == 0 && fl_cyc && fl_stb) begin
          ph = 1; scnt = stall_cfg; acnt = ack_cfg; cur = fl_addr; stb_cnt++;
        end
        if (ph == 1) begin
          if (scnt > 0) begin
            fl_stall = 1'b1; scnt--;
          end else begin
            fl_stall = 1'b0;
            if (acnt == 0) begin fl_ack = 1'b1; fl_data = flash_word(cur); ph = 0; end
            else ph = 2;
          end
        end else if (ph == 2) begin
          acnt--;
          if (acnt == 0) begin fl_ack = 1'b1; fl_data = flash_word(cur); ph = 0; end
        end
      end
    end
  end

  // Reference model: scratch bytes plus the word address owning each cache index (-1 = empty)
  bit [7:0] ref_scr [4096];
  int       owner [16];

  task automatic clear_owners();
    for (int i = 0; i < 16; i++) owner[i] = -1;
  endtask

  task automatic ref_predict(input logic wr, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be, input int st, input int ak,
                             output logic [31:0] ed, output logic ee, output int el, output int ef);
    int base, idx;
    logic [21:0] wa;
    ed = '0; ee = 1'b0; el = 2; ef = 0;
    if (a < 32'd4096) begin
      base = int'(a & 32'hFFC);
      for (int k = 0; k < 4; k++) begin
        if (wr && be[k]) ref_scr[base+k] = d[8*k +: 8];
        if (!wr) ed[8*k +: 8] = ref_scr[base+k];
      end
    end else if (wr) begin
      ee = 1'b1;
    end else begin
      wa  = a[23:2];
      idx = int'(wa) % 16;
      ed  = flash_word(wa);
      if (owner[idx] != int'(wa)) begin
        owner[idx] = int'(wa);
        el = 3 + st + ak;
        ef = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_req(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(posedge clk); #1;
    memory_access = 1'b1; memory_is_writing = wr; addr = a; d_in = d; mem_be = be;
  endtask

  task automatic wait_rsp(input int prog_at, output logic [31:0] dat, output logic err, output int lat);
    logic seen;
    seen = 1'b0; dat = '0; err = 1'b0; lat = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (lat == prog_at) set_programming_mode = 1'b1;
      if (out_valid) begin seen = 1'b1; dat = d_out; err = out_err; end
    end
    memory_access = 1'b0;
    chk("rsp_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    chk("rsp_pulse", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic do_access(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                           input int st, input int ak, input string tag, input int prog_at,
                           output logic [31:0] gd);
    logic [31:0] ed;
    logic ee, ge;
    int el, ef, gl, s0;
    ref_predict(wr, a, d, be, st, ak, ed, ee, el, ef);
    stall_cfg = st; ack_cfg = ak; s0 = stb_cnt;
    start_req(wr, a, d, be);
    wait_rsp(prog_at, gd, ge, gl);
    chk({tag, "_err"}, {31'd0, ge}, {31'd0, ee});
    if (!ee) chk({tag, "_data"}, gd, ed);
    chk({tag, "_lat"}, 32'(gl), 32'(el));
    chk({tag, "_fetches"}, 32'(stb_cnt - s0), 32'(ef));
  endtask

  task automatic flush_pulse();
    @(posedge clk); #1 cache_flush = 1'b1;
    @(posedge clk); #1 cache_flush = 1'b0;
    clear_owners();
  endtask

  initial begin
    logic [31:0] gd, a, d;
    logic [21:0] wa;
    logic seen;
    int kind, st, ak;
    clear_owners();
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_d_out", d_out, 32'd0);
    chk("rst_prog_active", {31'd0, prog_active}, 32'd0);
    chk("rst_fl_cyc_stb", {30'd0, fl_cyc, fl_stb}, 32'd0);
    chk("rst_sram_cen_wen", {30'd0, sram_cen, sram_wen}, 32'd3);
    chk("rst_ext_pins", {29'd0, ext_spi_cs_n, ext_spi_sck, ext_spi_mosi}, 32'b010);
    chk("rst_miso", {30'd0, fl_spi_miso, prog_spi_miso}, 32'b11);
    @(negedge clk) rst = 1'b1;

    // scratch byte-enable write then read back
    do_access(1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, 0, 0, "sram_wr", -1, gd);
    chk("sram_wr_zero_dout", gd, 32'h0);
    do_access(1'b0, 32'h10, 32'h0, 4'hF, 0, 0, "sram_rd", -1, gd);
    chk("sram_rd_value", gd, 32'h00BB00DD);

    // cold miss, then hit, then conflict eviction on index 0
    do_access(1'b0, 32'h2000, 32'h0, 4'h0, 2, 3, "cold", -1, gd);
    chk("cold_value", gd, 32'h12345678);
    do_access(1'b0, 32'h2000, 32'h0, 4'h0, 2, 3, "hit", -1, gd);
    do_access(1'b0, 32'h2040, 32'h0, 4'h0, 1, 1, "evict_a", -1, gd);
    do_access(1'b0, 32'h2000, 32'h0, 4'h0, 0, 0, "evict_b", -1, gd);
    do_access(1'b0, 32'h7F002000, 32'h0, 4'h0, 0, 0, "alias_hit", -1, gd);

    // rejected flash write
    do_access(1'b1, 32'h3000, 32'hDEADBEEF, 4'hF, 0, 0, "fl_write", -1, gd);

    // flush forces a refetch
    flush_pulse();
    do_access(1'b0, 32'h2000, 32'h0, 4'h0, 1, 2, "post_flush", -1, gd);

    // programming request during a miss: the miss completes first
    do_access(1'b0, 32'h2400, 32'h0, 4'h0, 3, 2, "prog_miss", 2, gd);
    chk("prog_entered", {31'd0, prog_active}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      {prog_spi_cs_n, prog_spi_sck, prog_spi_mosi} = 3'($urandom);
      ext_spi_miso = 1'($urandom);
      #1;
      chk("prog_pins", {29'd0, ext_spi_cs_n, ext_spi_sck, ext_spi_mosi},
          {29'd0, prog_spi_cs_n, prog_spi_sck, prog_spi_mosi});
      chk("prog_miso", {30'd0, prog_spi_miso, fl_spi_miso}, {30'd0, ext_spi_miso, 1'b1});
    end
    @(negedge clk);
    memory_access = 1'b1; memory_is_writing = 1'b0; addr = 32'h10;
    seen = 1'b0;
    repeat (4) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    memory_access = 1'b0;
    chk("prog_ignores_access", {31'd0, seen}, 32'd0);
    set_programming_mode = 1'b0;
    gen = gen + 10'd1;
    fixed_2000 = 32'hCAFEF00D;
    clear_owners();
    @(negedge clk); #1;
    chk("prog_left", {31'd0, prog_active}, 32'd0);
    chk("fl_pins_back", {29'd0, ext_spi_cs_n, ext_spi_sck, ext_spi_mosi},
        {29'd0, fl_spi_cs_n, fl_spi_sck, fl_spi_mosi});
    do_access(1'b0, 32'h2000, 32'h0, 4'h0, 0, 1, "post_prog", -1, gd);
    chk("post_prog_value", gd, 32'hCAFEF00D);

    // reset while waiting for the flash ack
    stall_cfg = 0; ack_cfg = 20;
    start_req(1'b0, 32'h2800, 32'h0, 4'h0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    memory_access = 1'b0;
    #1;
    chk("rst_mid_fl_cyc", {31'd0, fl_cyc}, 32'd0);
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    clear_owners();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    do_access(1'b0, 32'h2000, 32'h0, 4'h0, 1, 0, "post_rst", -1, gd);

    // random traffic
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 19);
      st = $urandom_range(0, 3);
      ak = $urandom_range(0, 4);
      d  = $urandom;
      if (kind == 0) begin
        flush_pulse();
      end else if (kind <= 5) begin
        a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
        do_access(1'b1, a, d, 4'($urandom), st, ak, "rnd_sram_wr", -1, gd);
      end else if (kind <= 9) begin
        a = 32'($urandom_range(0, 63)) * 4;
        do_access(1'b0, a, d, 4'hF, st, ak, "rnd_sram_rd", -1, gd);
      end else if (kind <= 17) begin
        wa = 22'h800 + 22'($urandom_range(0, 3)) * 22'd16 + 22'($urandom_range(0, 3));
        a = {8'($urandom), wa, 2'($urandom)};
        do_access(1'b0, a, d, 4'h0, st, ak, "rnd_fl_rd", -1, gd);
      end else begin
        a = 32'h1000 + 32'($urandom_range(0, 32'hFFFFF));
        do_access(1'b1, a, d, 4'hF, st, ak, "rnd_fl_wr", -1, gd);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed no completion expected finish before timeout");
    $fatal(1, "watchdog");
  end
endmodule
